// File: rtl/uart_meas_frame_tx.sv
// UART framer for measurement channels: header tag, value bytes MSB-first, trailer tag,
// round-robin over unmasked channels with a programmable idle gap between frames.
module uart_meas_frame_tx #(
    parameter int                  CLK_DIV    = 5208,
    parameter int                  NUM_CH     = 3,
    parameter int                  DATA_W     = 32,
    parameter int                  GAP_CYC    = 2_400_000,
    parameter bit                  PARITY_EN  = 1'b0,
    parameter bit                  PARITY_ODD = 1'b0,
    parameter logic [NUM_CH*8-1:0] HDR_TAGS   = {8'h64, 8'h63, 8'h74},
    parameter logic [NUM_CH*8-1:0] TRL_TAGS   = {8'h75, 8'h79, 8'h78},
    localparam int                 CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     auto_en,
    input  logic                     start,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [CH_W-1:0]          cur_ch
);
    localparam int NB       = DATA_W / 8 + 2;
    localparam int NV       = DATA_W / 8;
    localparam int BI_W     = $clog2(NB);
    localparam int TMR_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W    = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LAST);

    typedef enum logic [2:0] {
        S_IDLE, S_SEEK, S_LOAD, S_START, S_DATA, S_PAR, S_STOP, S_GAP
    } state_t;

    state_t              state_reg, state_next;
    logic [TMR_W-1:0]    tmr_reg, tmr_next;
    logic [GAP_W-1:0]    gap_reg, gap_next;
    logic [2:0]          bit_reg, bit_next;
    logic [BI_W-1:0]     byte_reg, byte_next;
    logic [DATA_W-1:0]   snap_reg, snap_next;
    logic [CH_W-1:0]     sel_reg, sel_next;
    logic [CH_W-1:0]     cur_ch_reg, cur_ch_next;
    logic                tx_reg, tx_next;
    logic                done_reg, done_next;

    logic [DATA_W-1:0]   ch_val   [NUM_CH];
    logic [7:0]          hdr_tag  [NUM_CH];
    logic [7:0]          trl_tag  [NUM_CH];
    logic [7:0]          val_byte [NV];
    logic [7:0]          cur_byte;
    logic                par_bit;
    logic                found;
    logic [CH_W-1:0]     seek_ch;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_val[gi]  = ch_data[gi*DATA_W +: DATA_W];
            assign hdr_tag[gi] = HDR_TAGS[gi*8 +: 8];
            assign trl_tag[gi] = TRL_TAGS[gi*8 +: 8];
        end
        for (gi = 0; gi < NV; gi++) begin : g_val
            assign val_byte[gi] = snap_reg[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    // Byte on the wire: header, snapshot bytes MSB-first, trailer.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch_reg == CH_W'(i)) begin
                if (byte_reg == '0)
                    cur_byte = hdr_tag[i];
                else if (byte_reg == BI_W'(NB - 1))
                    cur_byte = trl_tag[i];
            end
        end
        for (int i = 0; i < NV; i++) begin
            if (byte_reg == BI_W'(i + 1))
                cur_byte = val_byte[i];
        end
        par_bit = (^cur_byte) ^ PARITY_ODD;
    end

    // Wrap-around search from cur_ch; descending offsets so the nearest enabled channel wins.
    always_comb begin
        found   = 1'b0;
        seek_ch = cur_ch_reg;
        for (int j = 0; j < NUM_CH; j++) begin
            if (cur_ch_reg == CH_W'(j)) begin
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (ch_mask[(j + i) % NUM_CH]) begin
                        found   = 1'b1;
                        seek_ch = CH_W'((j + i) % NUM_CH);
                    end
                end
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        tmr_next    = tmr_reg;
        gap_next    = gap_reg;
        bit_next    = bit_reg;
        byte_next   = byte_reg;
        snap_next   = snap_reg;
        sel_next    = sel_reg;
        cur_ch_next = cur_ch_reg;
        done_next   = 1'b0;
        tx_next     = 1'b1;
        case (state_reg)
            S_IDLE: begin
                if (auto_en || start)
                    state_next = S_SEEK;
            end
            S_SEEK: begin
                if (found) begin
                    sel_next   = seek_ch;
                    state_next = S_LOAD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel_reg == CH_W'(i))
                        snap_next = ch_val[i];
                end
                cur_ch_next = sel_reg;
                byte_next   = '0;
                bit_next    = 3'd0;
                tmr_next    = '0;
                state_next  = S_START;
            end
            S_START, S_DATA, S_PAR, S_STOP: begin
                if (tmr_reg == TMR_MAX) begin
                    tmr_next = '0;
                    case (state_reg)
                        S_START: begin
                            bit_next   = 3'd0;
                            state_next = S_DATA;
                        end
                        S_DATA: begin
                            if (bit_reg == 3'd7)
                                state_next = PARITY_EN ? S_PAR : S_STOP;
                            else
                                bit_next = bit_reg + 3'd1;
                        end
                        S_PAR: state_next = S_STOP;
                        default: begin
                            if (byte_reg == BI_W'(NB - 1)) begin
                                done_next   = 1'b1;
                                cur_ch_next = (cur_ch_reg == CH_W'(NUM_CH - 1)) ? '0
                                                                                : cur_ch_reg + CH_W'(1);
                                gap_next    = '0;
                                state_next  = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                            end else begin
                                byte_next  = byte_reg + BI_W'(1);
                                state_next = S_START;
                            end
                        end
                    endcase
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (gap_reg == GAP_MAX) begin
                    gap_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Line level is registered from the upcoming state so each bit starts on a clean edge.
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = cur_byte[bit_next];
            S_PAR:   tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            tmr_reg    <= '0;
            gap_reg    <= '0;
            bit_reg    <= 3'd0;
            byte_reg   <= '0;
            snap_reg   <= '0;
            sel_reg    <= '0;
            cur_ch_reg <= '0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tmr_reg    <= tmr_next;
            gap_reg    <= gap_next;
            bit_reg    <= bit_next;
            byte_reg   <= byte_next;
            snap_reg   <= snap_next;
            sel_reg    <= sel_next;
            cur_ch_reg <= cur_ch_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
        end
    end

    assign uart_tx    = tx_reg;
    assign frame_done = done_reg;
    assign cur_ch     = cur_ch_reg;
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_SEEK);
endmodule

// File: tb/tb_uart_meas_frame_tx.sv
// Directed bench for uart_meas_frame_tx: a 3-channel framer and a 1-channel parity framer
// decoded by a mid-bit sampling UART receiver.
module tb_uart_meas_frame_tx;
    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 10;
    localparam int NUM_CH  = 3;
    localparam int DATA_W  = 32;
    localparam int NB      = DATA_W / 8 + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_mask;
    logic                     auto_en, start;
    logic                     uart_tx, busy, frame_done;
    logic [1:0]               cur_ch;

    logic [7:0] ch_data_p;
    logic       ch_mask_p, start_p, auto_en_p;
    logic       uart_tx_p, busy_p, frame_done_p, cur_ch_p;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int fdp_cyc = 0;

    uart_meas_frame_tx #(
        .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC),
        .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
        .HDR_TAGS({8'h64, 8'h63, 8'h74}), .TRL_TAGS({8'h75, 8'h79, 8'h78})
    ) u_dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_mask(ch_mask), .auto_en(auto_en),
        .start(start), .uart_tx(uart_tx), .busy(busy), .frame_done(frame_done), .cur_ch(cur_ch)
    );

    uart_meas_frame_tx #(
        .CLK_DIV(CLK_DIV), .NUM_CH(1), .DATA_W(8), .GAP_CYC(GAP_CYC),
        .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
        .HDR_TAGS(8'hA5), .TRL_TAGS(8'h5A)
    ) u_par (
        .clk(clk), .rst(rst), .ch_data(ch_data_p), .ch_mask(ch_mask_p), .auto_en(auto_en_p),
        .start(start_p), .uart_tx(uart_tx_p), .busy(busy_p), .frame_done(frame_done_p),
        .cur_ch(cur_ch_p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (frame_done_p)
            fdp_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? uart_tx_p : uart_tx;
    endfunction

    task automatic wait_start(input bit sel, output int s);
        int n = 0;
        @(negedge clk);
        while (line(sel) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 64'(line(sel)), 64'd0);
        s = cyc;
    endtask

    task automatic rx_byte(input bit sel, output logic [7:0] b, output bit p, output int s);
        wait_start(sel, s);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            b[i] = line(sel);
        end
        p = 1'b0;
        if (sel) begin
            repeat (CLK_DIV) @(negedge clk);
            p = line(sel);
        end
        repeat (CLK_DIV) @(negedge clk);
        chk("stop_bit", 64'(line(sel)), 64'd1);
    endtask

    task automatic rx_frame(output logic [NB*8-1:0] f, output int s0);
        logic [7:0] b;
        bit         p;
        int         s;
        f  = '0;
        s0 = 0;
        for (int k = 0; k < NB; k++) begin
            rx_byte(1'b0, b, p, s);
            if (k == 0)
                s0 = s;
            f[8*(NB-1-k) +: 8] = b;
        end
        $display("frame %012h starts at cycle %0d", f, s0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [NB*8-1:0] f;
        logic [7:0]      b;
        bit              p;
        int              s0, s, t, e, n, bc, hi_cnt, lo_cnt, fd_before;

        ch_data   = {32'hDEAD_BEEF, 32'hCAFE_0001, 32'h1234_5678};
        ch_mask   = 3'b001;
        auto_en   = 1'b0;
        start     = 1'b0;
        ch_data_p = 8'h07;
        ch_mask_p = 1'b1;
        auto_en_p = 1'b0;
        start_p   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 64'(uart_tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_cur_ch", 64'(cur_ch), 64'd0);
        chk("rst_tx_par", 64'(uart_tx_p), 64'd1);

        // 1: single frame on channel 0
        fd_before = fd_cnt;
        t = cyc;
        pulse_start();
        rx_frame(f, s0);
        chk("t1_frame", 64'(f), 64'h74_12_34_56_78_78);
        chk("t1_latency", 64'(s0 - t), 64'd3);
        repeat (20) @(negedge clk);
        chk("t1_done_cnt", 64'(fd_cnt - fd_before), 64'd1);
        chk("t1_frame_len", 64'(fd_cyc - s0), 64'(NB * 10 * CLK_DIV));
        chk("t1_cur_ch", 64'(cur_ch), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // 2: free-running over all channels
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t2_cur_ch_rst", 64'(cur_ch), 64'd0);
        ch_mask = 3'b111;
        auto_en = 1'b1;
        rx_frame(f, s0);
        chk("t2_frame0", 64'(f), 64'h74_12_34_56_78_78);
        n = 0;
        while (!frame_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        e  = cyc;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("t2_gap_busy", 64'(bc), 64'(GAP_CYC));
        rx_frame(f, s0);
        chk("t2_frame1", 64'(f), 64'h63_CA_FE_00_01_79);
        // line idle = gap plus the IDLE, SEEK and LOAD cycles
        chk("t2_gap_idle", 64'(s0 - e), 64'(GAP_CYC + 3));
        rx_frame(f, s0);
        chk("t2_frame2", 64'(f), 64'h64_DE_AD_BE_EF_75);
        rx_frame(f, s0);
        chk("t2_frame3", 64'(f), 64'h74_12_34_56_78_78);
        auto_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("t2_idle_busy", 64'(busy), 64'd0);
        chk("t2_cur_ch", 64'(cur_ch), 64'd1);

        // 3: masked channel 1, then everything masked
        ch_mask = 3'b101;
        auto_en = 1'b1;
        rx_frame(f, s0);
        chk("t3_frame0", 64'(f), 64'h64_DE_AD_BE_EF_75);
        rx_frame(f, s0);
        chk("t3_frame1", 64'(f), 64'h74_12_34_56_78_78);
        rx_frame(f, s0);
        chk("t3_frame2", 64'(f), 64'h64_DE_AD_BE_EF_75);
        rx_frame(f, s0);
        chk("t3_frame3", 64'(f), 64'h74_12_34_56_78_78);
        auto_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("t3_cur_ch", 64'(cur_ch), 64'd1);
        ch_mask = 3'b000;
        auto_en = 1'b1;
        hi_cnt  = 0;
        lo_cnt  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) hi_cnt++;
            if (!uart_tx) lo_cnt++;
        end
        auto_en = 1'b0;
        chk("t3_mask0_busy", 64'(hi_cnt), 64'd0);
        chk("t3_mask0_tx", 64'(lo_cnt), 64'd0);
        chk("t3_mask0_cur_ch", 64'(cur_ch), 64'd1);

        // 4: channel data changes right after the snapshot
        ch_mask = 3'b001;
        ch_data[31:0] = 32'hAAAA_AAAA;
        @(negedge clk);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        ch_data[31:0] = 32'h5555_5555;
        rx_frame(f, s0);
        chk("t4_frame", 64'(f), 64'h74_AA_AA_AA_AA_78);
        repeat (20) @(negedge clk);

        // 5: reset in the middle of the first value byte
        ch_mask = 3'b100;
        ch_data[95:64] = 32'h0000_BEEF;
        pulse_start();
        rx_byte(1'b0, b, p, s);
        chk("t5_hdr", 64'(b), 64'h64);
        wait_start(1'b0, s);
        repeat (10) @(negedge clk);
        chk("t5_pre_rst_tx", 64'(uart_tx), 64'd0);
        chk("t5_pre_rst_cur_ch", 64'(cur_ch), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_tx", 64'(uart_tx), 64'd1);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_cur_ch", 64'(cur_ch), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ch_mask = 3'b111;
        ch_data[31:0] = 32'h1234_5678;
        @(negedge clk);
        pulse_start();
        rx_frame(f, s0);
        chk("t5_frame", 64'(f), 64'h74_12_34_56_78_78);
        repeat (20) @(negedge clk);

        // 6: even parity, 11-bit bytes
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        rx_byte(1'b1, b, p, s0);
        chk("t6_hdr", 64'(b), 64'hA5);
        chk("t6_hdr_par", 64'(p), 64'd0);
        rx_byte(1'b1, b, p, s);
        chk("t6_data", 64'(b), 64'h07);
        chk("t6_data_par", 64'(p), 64'd1);
        rx_byte(1'b1, b, p, s);
        chk("t6_trl", 64'(b), 64'h5A);
        chk("t6_trl_par", 64'(p), 64'd0);
        repeat (10) @(negedge clk);
        chk("t6_frame_len", 64'(fdp_cyc - s0), 64'(3 * 11 * CLK_DIV));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
